// File: rtl/ftoi_pipe.sv
// Pipelined binary32 to signed/unsigned integer converter with IEEE rounding modes,
// saturation on overflow/NaN and a single global stall (adv) shared by every stage.
module ftoi_pipe #(
   parameter int INT_W  = 32,
   parameter int STAGES = 2
) (
   input  logic             sys_clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_x,
   input  logic [2:0]       in_rm,
   input  logic             in_unsigned,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [INT_W-1:0] out_y,
   output logic             out_nv,
   output logic             out_nx
);

   localparam int              MW     = INT_W + 1;
   localparam logic signed [8:0] BIG_SH = 9'(INT_W - 23);

   typedef struct packed {
      logic        sign;
      logic        nan;
      logic [8:0]  sh;
      logic [23:0] mant;
      logic [2:0]  rm;
      logic        uns;
   } rec_t;

   typedef struct packed {
      logic [INT_W-1:0] y;
      logic             nv;
      logic             nx;
   } res_t;

   // sh is the signed left-shift that turns the 24-bit significand into the integer value
   function automatic rec_t unpack_f(input logic [31:0] x, input logic [2:0] rm, input logic uns);
      rec_t       r;
      logic [7:0] e;
      e      = x[30:23];
      r.sign = x[31];
      r.nan  = (e == 8'hFF) && (x[22:0] != 23'd0);
      r.mant = {(e != 8'd0), x[22:0]};
      if (e == 8'd0) begin
         r.sh = 9'd1 - 9'd150;
      end else begin
         r.sh = {1'b0, e} - 9'd150;
      end
      r.rm  = rm;
      r.uns = uns;
      return r;
   endfunction

   function automatic res_t convert_f(input rec_t r);
      res_t              o;
      logic signed [8:0] sh;
      logic [8:0]        neg_sh;
      logic [4:0]        rsh;
      logic [48:0]       al;
      logic [MW-1:0]     ip;
      logic [MW-1:0]     mag;
      logic [MW-1:0]     neg_mag;
      logic              big;
      logic              g;
      logic              s;
      logic              inc;
      logic              nv;
      sh     = $signed(r.sh);
      big    = (sh > BIG_SH);
      neg_sh = 9'd0 - r.sh;
      rsh    = 5'd0;
      al     = 49'd0;
      if (sh >= 9'sd0) begin
         ip = {{(MW-24){1'b0}}, r.mant} << sh[6:0];
         g  = 1'b0;
         s  = 1'b0;
      end else begin
         // Shifts beyond 25 leave every significand bit in the sticky position
         if (neg_sh > 9'd25) begin
            rsh = 5'd25;
         end else begin
            rsh = neg_sh[4:0];
         end
         al = {r.mant, 25'd0} >> rsh;
         ip = {{(MW-24){1'b0}}, al[48:25]};
         g  = al[24];
         s  = |al[23:0];
      end
      case (r.rm)
         3'b001:  inc = 1'b0;
         3'b010:  inc = r.sign & (g | s);
         3'b011:  inc = ~r.sign & (g | s);
         3'b100:  inc = g;
         default: inc = g & (s | ip[0]);
      endcase
      mag     = ip + {{(MW-1){1'b0}}, inc};
      neg_mag = {MW{1'b0}} - mag;
      if (r.nan) begin
         o.y = r.uns ? {INT_W{1'b1}} : {1'b0, {(INT_W-1){1'b1}}};
         nv  = 1'b1;
      end else if (r.uns) begin
         if (r.sign) begin
            o.y = {INT_W{1'b0}};
            nv  = big || (mag != {MW{1'b0}});
         end else if (big || mag[INT_W]) begin
            o.y = {INT_W{1'b1}};
            nv  = 1'b1;
         end else begin
            o.y = mag[INT_W-1:0];
            nv  = 1'b0;
         end
      end else begin
         if (r.sign) begin
            if (big || (mag > {2'b01, {(INT_W-1){1'b0}}})) begin
               o.y = {1'b1, {(INT_W-1){1'b0}}};
               nv  = 1'b1;
            end else begin
               o.y = neg_mag[INT_W-1:0];
               nv  = 1'b0;
            end
         end else if (big || (mag > {2'b00, {(INT_W-1){1'b1}}})) begin
            o.y = {1'b0, {(INT_W-1){1'b1}}};
            nv  = 1'b1;
         end else begin
            o.y = mag[INT_W-1:0];
            nv  = 1'b0;
         end
      end
      o.nv = nv;
      o.nx = (g | s) & ~nv;
      return o;
   endfunction

   rec_t in_rec_s;
   rec_t last_rec_s;
   logic last_vld_s;
   res_t res_s;
   logic adv_s;

   assign adv_s    = out_ready | ~out_valid;
   assign in_ready = adv_s;

   // Stage-1 unpack of the incoming operand
   always_comb begin
      in_rec_s = unpack_f(in_x, in_rm, in_unsigned);
   end

   generate
      if (STAGES == 1) begin : g_direct
         assign last_rec_s = in_rec_s;
         assign last_vld_s = in_valid;
      end else begin : g_stages
         rec_t              rec_r [STAGES-1];
         logic [STAGES-2:0] vld_r;

         // Unpacked records and their valid bits move one slot per advance
         always_ff @(posedge sys_clk or negedge rst) begin
            if (!rst) begin
               vld_r <= {(STAGES-1){1'b0}};
               for (int k = 0; k < STAGES-1; k++) begin
                  rec_r[k] <= {$bits(rec_t){1'b0}};
               end
            end else if (adv_s) begin
               vld_r[0] <= in_valid;
               rec_r[0] <= in_rec_s;
               for (int k = 1; k < STAGES-1; k++) begin
                  vld_r[k] <= vld_r[k-1];
                  rec_r[k] <= rec_r[k-1];
               end
            end
         end

         assign last_rec_s = rec_r[STAGES-2];
         assign last_vld_s = vld_r[STAGES-2];
      end
   endgenerate

   // Alignment, rounding, range check and negation ahead of the output register
   always_comb begin
      res_s = convert_f(last_rec_s);
   end

   // Output register, held whenever the consumer stalls
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_y     <= {INT_W{1'b0}};
         out_nv    <= 1'b0;
         out_nx    <= 1'b0;
      end else if (adv_s) begin
         out_valid <= last_vld_s;
         out_y     <= res_s.y;
         out_nv    <= res_s.nv;
         out_nx    <= res_s.nx;
      end
   end

endmodule

// File: tb/tb_ftoi_pipe.sv
// Scoreboard bench for ftoi_pipe: directed vectors with hand-computed results,
// a stall burst, and a reset with beats in flight.
module tb_ftoi_pipe;

   localparam int INT_W  = 32;
   localparam int STAGES = 2;

   logic             sys_clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_x;
   logic [2:0]       in_rm;
   logic             in_unsigned;
   logic             out_valid;
   logic             out_ready;
   logic [INT_W-1:0] out_y;
   logic             out_nv;
   logic             out_nx;

   ftoi_pipe #(.INT_W(INT_W), .STAGES(STAGES)) dut (
      .sys_clk     (sys_clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_x        (in_x),
      .in_rm       (in_rm),
      .in_unsigned (in_unsigned),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_y       (out_y),
      .out_nv      (out_nv),
      .out_nx      (out_nx)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic        nv;
      logic        nx;
      int          lat;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t e_m;

   logic        held_v = 1'b0;
   logic [31:0] held_y;
   logic        held_nv;
   logic        held_nx;

   // Monitor: pops the scoreboard on every delivered beat and checks stall holding
   always @(negedge sys_clk) begin
      if (rst) begin
         if (held_v) begin
            checks++;
            if (!out_valid || out_y !== held_y || out_nv !== held_nv || out_nx !== held_nx) begin
               failures++;
               $display("FAIL stall_hold: got valid=%b y=%h nv=%b nx=%b, required valid=1 y=%h nv=%b nx=%b",
                        out_valid, out_y, out_nv, out_nx, held_y, held_nv, held_nx);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_beat: got y=%h nv=%b nx=%b, required no output", out_y, out_nv, out_nx);
            end else begin
               e_m = exp_q.pop_front();
               if (out_y !== e_m.y || out_nv !== e_m.nv || out_nx !== e_m.nx) begin
                  failures++;
                  $display("FAIL result x=%h: got y=%h nv=%b nx=%b, required y=%h nv=%b nx=%b",
                           e_m.x, out_y, out_nv, out_nx, e_m.y, e_m.nv, e_m.nx);
               end
               if (e_m.lat != 0) begin
                  checks++;
                  if (cyc - e_m.cyc != e_m.lat) begin
                     failures++;
                     $display("FAIL latency x=%h: got %0d cycles, required %0d", e_m.x, cyc - e_m.cyc, e_m.lat);
                  end
               end
            end
         end
         held_v  = out_valid && !out_ready;
         held_y  = out_y;
         held_nv = out_nv;
         held_nx = out_nx;
      end else begin
         held_v = 1'b0;
      end
   end

   task automatic send(input logic [31:0] x, input logic [2:0] rm, input logic uns,
                       input logic [31:0] y, input logic nv, input logic nx, input int lat);
      exp_t e;
      int   waited;
      in_valid    = 1'b1;
      in_x        = x;
      in_rm       = rm;
      in_unsigned = uns;
      waited      = 0;
      @(negedge sys_clk);
      while (!in_ready && waited < 200) begin
         @(negedge sys_clk);
         waited++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout x=%h: in_ready=%b, required 1", x, in_ready);
      end else begin
         e.x   = x;
         e.y   = y;
         e.nv  = nv;
         e.nx  = nx;
         e.lat = lat;
         e.cyc = cyc;
         exp_q.push_back(e);
      end
      @(posedge sys_clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge sys_clk);
         n++;
      end
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      rst         = 1'b0;
      in_valid    = 1'b0;
      in_x        = 32'h0;
      in_rm       = 3'b000;
      in_unsigned = 1'b0;
      out_ready   = 1'b1;
      #12;
      checks++;
      if (out_valid !== 1'b0 || out_y !== 32'h0 || out_nv !== 1'b0 || out_nx !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: got valid=%b y=%h nv=%b nx=%b, required all 0", out_valid, out_y, out_nv, out_nx);
      end
      @(posedge sys_clk); #1;
      rst = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL ready_after_reset: got %b, required 1", in_ready);
      end
      @(posedge sys_clk); #1;

      // Directed vectors: x, rm, unsigned, expected y, nv, nx
      send(32'h40200000, 3'b000, 1'b0, 32'h00000002, 1'b0, 1'b1, STAGES);
      send(32'h40200000, 3'b001, 1'b0, 32'h00000002, 1'b0, 1'b1, STAGES);
      send(32'h40200000, 3'b011, 1'b0, 32'h00000003, 1'b0, 1'b1, STAGES);
      send(32'h40200000, 3'b100, 1'b0, 32'h00000003, 1'b0, 1'b1, STAGES);
      send(32'hBFC00000, 3'b010, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1, STAGES);
      send(32'hBFC00000, 3'b000, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1, STAGES);
      send(32'hBFC00000, 3'b001, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, STAGES);
      send(32'h4F32D05E, 3'b000, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, STAGES);
      send(32'h4F32D05E, 3'b000, 1'b1, 32'hB2D05E00, 1'b0, 1'b0, STAGES);
      send(32'h7FC00000, 3'b000, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, STAGES);
      send(32'hFFC00000, 3'b001, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, STAGES);
      send(32'hBF000000, 3'b000, 1'b1, 32'h00000000, 1'b0, 1'b1, STAGES);
      send(32'hBF000000, 3'b010, 1'b1, 32'h00000000, 1'b1, 1'b0, STAGES);
      send(32'h00000000, 3'b000, 1'b0, 32'h00000000, 1'b0, 1'b0, STAGES);
      send(32'h80000000, 3'b010, 1'b0, 32'h00000000, 1'b0, 1'b0, STAGES);
      send(32'h00000001, 3'b011, 1'b0, 32'h00000001, 1'b0, 1'b1, STAGES);
      send(32'h00000001, 3'b000, 1'b0, 32'h00000000, 1'b0, 1'b1, STAGES);
      send(32'h80000001, 3'b010, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, STAGES);
      send(32'h80000001, 3'b011, 1'b1, 32'h00000000, 1'b0, 1'b1, STAGES);
      send(32'hCF000000, 3'b001, 1'b0, 32'h80000000, 1'b0, 1'b0, STAGES);
      send(32'hCF000001, 3'b000, 1'b0, 32'h80000000, 1'b1, 1'b0, STAGES);
      send(32'h4F000000, 3'b000, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, STAGES);
      send(32'h4F800000, 3'b000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, STAGES);
      send(32'h4F7FFFFF, 3'b000, 1'b1, 32'hFFFFFF00, 1'b0, 1'b0, STAGES);
      send(32'h7F800000, 3'b000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, STAGES);
      send(32'hFF800000, 3'b000, 1'b0, 32'h80000000, 1'b1, 1'b0, STAGES);
      send(32'h40200000, 3'b111, 1'b0, 32'h00000002, 1'b0, 1'b1, STAGES);
      send(32'h40600000, 3'b101, 1'b0, 32'h00000004, 1'b0, 1'b1, STAGES);
      send(32'hC0200000, 3'b100, 1'b0, 32'hFFFFFFFD, 1'b0, 1'b1, STAGES);
      send(32'h3F400000, 3'b001, 1'b0, 32'h00000000, 1'b0, 1'b1, STAGES);
      send(32'h3F400000, 3'b000, 1'b0, 32'h00000001, 1'b0, 1'b1, STAGES);
      send(32'hBF800000, 3'b001, 1'b1, 32'h00000000, 1'b1, 1'b0, STAGES);
      send(32'h3F800000, 3'b011, 1'b0, 32'h00000001, 1'b0, 1'b0, STAGES);
      wait_drain();

      // Back-to-back stream with a three-cycle consumer stall in the middle
      fork
         begin
            send(32'h3F800000, 3'b000, 1'b0, 32'h00000001, 1'b0, 1'b0, 0);
            send(32'h40000000, 3'b000, 1'b0, 32'h00000002, 1'b0, 1'b0, 0);
            send(32'h40400000, 3'b000, 1'b0, 32'h00000003, 1'b0, 1'b0, 0);
            send(32'h40800000, 3'b000, 1'b0, 32'h00000004, 1'b0, 1'b0, 0);
            send(32'h40A00000, 3'b000, 1'b0, 32'h00000005, 1'b0, 1'b0, 0);
            send(32'h40C00000, 3'b000, 1'b0, 32'h00000006, 1'b0, 1'b0, 0);
         end
         begin
            repeat (2) @(posedge sys_clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge sys_clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_drain();

      // Reset with two beats in flight
      repeat (2) @(posedge sys_clk);
      #1;
      send(32'h3F800000, 3'b000, 1'b0, 32'h00000001, 1'b0, 1'b0, STAGES);
      send(32'h40000000, 3'b000, 1'b0, 32'h00000002, 1'b0, 1'b0, STAGES);
      rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_y !== 32'h0 || out_nv !== 1'b0 || out_nx !== 1'b0) begin
         failures++;
         $display("FAIL reset_flush: got valid=%b y=%h nv=%b nx=%b, required all 0", out_valid, out_y, out_nv, out_nx);
      end
      exp_q.delete();
      @(posedge sys_clk); #1;
      rst = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL ready_after_rerelease: got %b, required 1", in_ready);
      end
      seen = 0;
      repeat (4) begin
         @(negedge sys_clk);
         if (out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL stale_beat: got %0d valid cycles, required 0", seen);
      end
      @(posedge sys_clk); #1;
      send(32'h40400000, 3'b000, 1'b0, 32'h00000003, 1'b0, 1'b0, STAGES);
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ftoi_pipe.md
FTOI_PIPE -- requirements
Module: ftoi_pipe

Interface
REQ-001 SHALL have parameter INT_W, default 32, integer result width; legal values 32 and 64.
REQ-002 SHALL have parameter STAGES, default 2, register stages from input to output; legal values 1..4.
REQ-003 sys_clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_x/in_rm/in_unsigned are valid this cycle.
REQ-006 in_ready  output  1  block accepts the input beat this cycle.
REQ-007 in_x  input  32  IEEE-754 binary32 operand.
REQ-008 in_rm  input  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
REQ-009 in_unsigned  input  1  1 = unsigned result, 0 = two's-complement signed result.
REQ-010 out_valid  output  1  out_y/out_nv/out_nx hold a result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 out_y  output  INT_W  converted integer.
REQ-013 out_nv  output  1  invalid-operation flag for this result.
REQ-014 out_nx  output  1  inexact flag for this result.

Function
REQ-015 SHALL use one global pipeline advance: adv = out_ready | ~out_valid; in_ready = adv.
REQ-016 An input beat SHALL be accepted on a cycle with in_valid & in_ready, and SHALL appear at the output exactly STAGES cycles later while adv stays 1.
REQ-017 When adv = 0, all stage registers, valid bits and outputs SHALL hold; no beat SHALL be dropped or duplicated.
REQ-018 Stage valid bits SHALL propagate independently, so bubbles pass through; sustained throughput SHALL be 1 beat/cycle.
REQ-019 Stage 1 SHALL unpack sign, exponent and {1,frac} (hidden bit 0 for exponent 0), and compute a 9-bit shift amount.
REQ-020 Alignment SHALL keep the integer part plus guard bit and sticky bit (OR of all lower bits); no mantissa bit SHALL be silently discarded.
REQ-021 Rounding SHALL be on the magnitude with direction set by sign and rm: RNE ties-to-even, RTZ truncate, RDN away from zero when negative, RUP away from zero when positive, RMM ties away from zero.
REQ-022 Reserved rm codes 101..111 SHALL behave as RNE.
REQ-023 out_nx SHALL be 1 iff guard|sticky is nonzero and out_nv is 0.
REQ-024 Signed range SHALL be [-2^(INT_W-1), 2^(INT_W-1)-1]: above range or +Inf -> max positive; below range or -Inf -> min negative; out_nv = 1.
REQ-025 Unsigned range SHALL be [0, 2^INT_W-1]: above range or +Inf -> all ones; a rounded result < 0 or -Inf -> 0; out_nv = 1.
REQ-026 A negative input that rounds to 0 in unsigned mode SHALL give 0 with out_nv = 0 and out_nx = 1.
REQ-027 Any NaN SHALL give max positive (signed) or all ones (unsigned), out_nv = 1, regardless of sign.
REQ-028 Exactly -2^(INT_W-1) in signed mode SHALL be valid with out_nv = 0.
REQ-029 ±0 SHALL give 0 with out_nv = 0 and out_nx = 0.
REQ-030 Subnormals SHALL be treated as tiny nonzero values: 0 or ±1 according to rm, out_nx = 1.
REQ-031 Negation to two's complement SHALL occur after rounding and range check.

Reset
REQ-032 On rst low, all stage valid bits and out_valid SHALL clear immediately; out_y, out_nv and out_nx SHALL go to 0.
REQ-033 Beats in flight when reset asserts SHALL be discarded.
REQ-034 in_ready SHALL be 1 from the first clock edge after rst deasserts.

Verification
REQ-035 RNE/RTZ/RUP/RMM on 0x40200000 (2.5), signed -> 2, 2, 3, 3; out_nx = 1 in all four cases.
REQ-036 0xBFC00000 (-1.5) signed: RDN and RNE -> 0xFFFFFFFE; RTZ -> 0xFFFFFFFF; out_nx = 1.
REQ-037 0x4F32D05E (3e9): signed -> 0x7FFFFFFF with out_nv = 1; unsigned -> 0xB2D05E00 with out_nv = 0 and out_nx = 0.
REQ-038 0x7FC00000: signed -> 0x7FFFFFFF, out_nv = 1; 0xBF000000 (-0.5) unsigned: RNE -> 0 (out_nx = 1), RDN -> 0 (out_nv = 1).
REQ-039 STAGES = 2, back-to-back beats with out_ready low for 3 cycles mid-stream -> outputs stable during the stall, all beats delivered in order, latency 2 when unstalled.
REQ-040 Assert rst with 2 beats in flight -> out_valid = 0 immediately; no stale beat after release; the first new beat has latency STAGES.
